// File: rtl/mpd_seq_pkg.sv
// Shared encodings and default constants for the MPD fabric configuration sequencer.
package mpd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam logic [47:0] MPD_MAGIC_DEFAULT    = 48'hFEEDBADCA77E;
    localparam logic [43:0] MPD_PAD_MASK_DEFAULT = 44'h01FFFFFFF80;

endpackage

// File: rtl/mpd_pulse_stretch.sv
// Two-flop synchroniser followed by a reloadable down-counter that stretches
// short activity pulses into a visible LED level.
module mpd_pulse_stretch #(
    parameter int STRETCH_BITS = 16
) (
    input  logic CLK,
    input  logic resetn,
    input  logic in,
    output logic out
);

    logic [1:0]              sync_q;
    logic [STRETCH_BITS-1:0] cnt_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], in};
            if (sync_q[1]) begin
                cnt_q <= '1;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign out = (cnt_q != '0);

endmodule

// File: rtl/mpd_fabric_sequencer.sv
// Qualifies the fabric done signature, releases pads to the fabric in staged
// groups and revokes them on reconfiguration. Optional MPD_SEQ_WATCHDOG_EN adds a fabric liveness watchdog.
module mpd_fabric_sequencer
    import mpd_seq_pkg::*;
#(
    parameter int                  NPADS        = 44,
    parameter logic [NPADS-1:0]    PAD_MASK     = MPD_PAD_MASK_DEFAULT,
    parameter int                  MAGIC_W      = 48,
    parameter logic [MAGIC_W-1:0]  MAGIC        = MPD_MAGIC_DEFAULT,
    parameter int                  QUAL_CYCLES  = 8,
    parameter int                  GROUP        = 4,
    parameter int                  STEP_CYCLES  = 16,
    parameter int                  HB_BITS      = 24,
    parameter int                  STRETCH_BITS = 16,
    parameter int                  WDT_BITS     = 20
) (
    input  logic               CLK,
    input  logic               resetn,
    input  logic [MAGIC_W-1:0] magic_word,
    input  logic               done_override,
    input  logic               cfg_active,
    input  logic               cfg_rx,
    input  logic               fab_alive,
    output logic [NPADS-1:0]   pad_release,
    output logic               fabric_done,
    output logic               heart_led,
    output logic               rx_led,
    output logic [1:0]         seq_state
);

    localparam int CUR_W  = $clog2(NPADS + GROUP) + 1;
    localparam int QCNT_W = $clog2(QUAL_CYCLES + 1) + 1;
    localparam int STEP_W = $clog2(STEP_CYCLES) + 1;

    localparam logic [CUR_W-1:0]  CUR_GROUP = CUR_W'(GROUP);
    localparam logic [CUR_W-1:0]  CUR_NPADS = CUR_W'(NPADS);
    localparam logic [QCNT_W-1:0] QUAL_LAST = QCNT_W'(QUAL_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    seq_state_e         state_q, state_d;
    logic               match_q;
    logic [QCNT_W-1:0]  qual_cnt_q, qual_cnt_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [NPADS-1:0]   pad_release_q, pad_release_d;
    logic               fabric_done_q, fabric_done_d;
    logic [HB_BITS-1:0] hb_q;
    logic               wdt_expired;

    // Eligible pads below the cursor; cursor values past NPADS simply select all pads.
    function automatic logic [NPADS-1:0] release_mask(input logic [CUR_W-1:0] cur);
        logic [NPADS-1:0] m;
        for (int i = 0; i < NPADS; i++) begin
            m[i] = PAD_MASK[i] && (CUR_W'(i) < cur);
        end
        return m;
    endfunction

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            match_q       <= 1'b0;
            qual_cnt_q    <= '0;
            cursor_q      <= '0;
            step_cnt_q    <= '0;
            pad_release_q <= '0;
            fabric_done_q <= 1'b0;
            hb_q          <= '0;
        end else begin
            state_q       <= state_d;
            match_q       <= (magic_word == MAGIC);
            qual_cnt_q    <= qual_cnt_d;
            cursor_q      <= cursor_d;
            step_cnt_q    <= step_cnt_d;
            pad_release_q <= pad_release_d;
            fabric_done_q <= fabric_done_d;
            hb_q          <= hb_q + 1'b1;
        end
    end

`ifdef MPD_SEQ_WATCHDOG_EN
    logic [2:0]          alive_q;
    logic [WDT_BITS-1:0] wdt_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            alive_q <= '0;
            wdt_q   <= '0;
        end else begin
            alive_q <= {alive_q[1:0], fab_alive};
            if ((state_q != ST_DONE) || (alive_q[2] ^ alive_q[1])) begin
                wdt_q <= '0;
            end else if (wdt_q != '1) begin
                wdt_q <= wdt_q + 1'b1;
            end
        end
    end

    assign wdt_expired = (wdt_q == '1);
`else
    localparam int unused_wdt_bits = WDT_BITS;
    logic unused_fab_alive;
    assign unused_fab_alive = fab_alive;
    assign wdt_expired      = 1'b0;
`endif

    // Priority: override, then revocation, then forward progress.
    always_comb begin
        state_d       = state_q;
        qual_cnt_d    = qual_cnt_q;
        cursor_d      = cursor_q;
        step_cnt_d    = step_cnt_q;
        pad_release_d = pad_release_q;
        fabric_done_d = fabric_done_q;
        if (done_override) begin
            state_d       = ST_DONE;
            pad_release_d = PAD_MASK;
            fabric_done_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (match_q) begin
                        state_d    = ST_QUAL;
                        qual_cnt_d = QCNT_W'(1);
                    end
                end
                ST_QUAL: begin
                    if (!match_q) begin
                        state_d    = ST_IDLE;
                        qual_cnt_d = '0;
                    end else if (qual_cnt_q >= QUAL_LAST) begin
                        state_d       = ST_RELEASE;
                        qual_cnt_d    = '0;
                        cursor_d      = CUR_GROUP;
                        step_cnt_d    = '0;
                        pad_release_d = release_mask(CUR_GROUP);
                    end else begin
                        qual_cnt_d = qual_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!match_q) begin
                        state_d       = ST_IDLE;
                        cursor_d      = '0;
                        step_cnt_d    = '0;
                        pad_release_d = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        step_cnt_d = '0;
                        cursor_d   = cursor_q + CUR_GROUP;
                        if (cursor_d >= CUR_NPADS) begin
                            state_d       = ST_DONE;
                            fabric_done_d = 1'b1;
                            pad_release_d = PAD_MASK;
                        end else begin
                            pad_release_d = release_mask(cursor_d);
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if ((cfg_active && !match_q) || wdt_expired) begin
                        state_d       = ST_IDLE;
                        cursor_d      = '0;
                        step_cnt_d    = '0;
                        pad_release_d = '0;
                        fabric_done_d = 1'b0;
                    end
                end
            endcase
        end
    end

    mpd_pulse_stretch #(
        .STRETCH_BITS(STRETCH_BITS)
    ) u_rx_stretch (
        .CLK   (CLK),
        .resetn(resetn),
        .in    (cfg_rx),
        .out   (rx_led)
    );

    assign pad_release = pad_release_q;
    assign fabric_done = fabric_done_q;
    assign heart_led   = hb_q[HB_BITS-1];
    assign seq_state   = state_q;

endmodule

// File: tb/tb_mpd_fabric_sequencer.sv
// Directed and randomized bench for mpd_fabric_sequencer, checked every cycle against a behavioural model.
module tb_mpd_fabric_sequencer;

    localparam int          NPADS = 44;
    localparam logic [43:0] PMASK = 44'h01FFFFFFF80;
    localparam logic [47:0] MAGIC = 48'hFEEDBADCA77E;
    localparam int          QUAL  = 8;
    localparam int          GROUP = 4;
    localparam int          STEP  = 16;
    localparam int          HB    = 10;
    localparam int          SB    = 12;
    localparam longint      SMAX  = (64'd1 << SB) - 1;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [47:0] magic_word;
    logic        done_override, cfg_active, cfg_rx, fab_alive;
    logic [43:0] pad_release;
    logic        fabric_done, heart_led, rx_led;
    logic [1:0]  seq_state;

    always #5 CLK = ~CLK;

    mpd_fabric_sequencer #(
        .HB_BITS     (HB),
        .STRETCH_BITS(SB)
    ) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .magic_word   (magic_word),
        .done_override(done_override),
        .cfg_active   (cfg_active),
        .cfg_rx       (cfg_rx),
        .fab_alive    (fab_alive),
        .pad_release  (pad_release),
        .fabric_done  (fabric_done),
        .heart_led    (heart_led),
        .rx_led       (rx_led),
        .seq_state    (seq_state)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_st;
    logic [43:0] m_rel;
    logic        m_done;
    bit          m_match;
    int          streak, elapsed;
    longint      k;
    bit          p1, p2, leff_v;
    longint      leff;

    function automatic logic [43:0] low_mask(input int n);
        logic [63:0] t;
        t = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return PMASK & t[43:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rel = '0; m_done = 1'b0; m_match = 1'b0;
        streak = 0; elapsed = 0; k = 0;
        p1 = 1'b0; p2 = 1'b0; leff_v = 1'b0; leff = 0;
    endtask

    task automatic model_step();
        bit m;
        int groups;
        if (!resetn) begin
            model_reset();
            return;
        end
        k++;
        m       = m_match;
        m_match = (magic_word == MAGIC);
        if (p2) begin
            leff   = k - 2;
            leff_v = 1'b1;
        end
        p2 = p1;
        p1 = cfg_rx;
        if (done_override) begin
            m_st = 3; m_rel = PMASK; m_done = 1'b1;
        end else begin
            case (m_st)
                0: if (m) begin m_st = 1; streak = 1; end
                1: begin
                    if (!m) begin
                        m_st = 0; streak = 0;
                    end else begin
                        streak++;
                        if (streak >= QUAL) begin
                            m_st = 2; elapsed = 0; m_rel = low_mask(GROUP);
                        end
                    end
                end
                2: begin
                    if (!m) begin
                        m_st = 0; m_rel = '0;
                    end else begin
                        elapsed++;
                        groups = 1 + elapsed / STEP;
                        if (groups * GROUP >= NPADS) begin
                            m_st = 3; m_done = 1'b1; m_rel = PMASK;
                        end else begin
                            m_rel = low_mask(groups * GROUP);
                        end
                    end
                end
                default: if (cfg_active && !m) begin
                    m_st = 0; m_rel = '0; m_done = 1'b0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("seq_state", 64'(seq_state), 64'(m_st));
        check("pad_release", 64'(pad_release), 64'(m_rel));
        check("fabric_done", 64'(fabric_done), 64'(m_done));
        check("heart_led", 64'(heart_led), 64'((k >> (HB - 1)) & 1));
        check("rx_led", 64'(rx_led), 64'(leff_v && (k <= leff + 1 + SMAX)));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        bit          seen_qual, seen_rel, hb_prev, hb_have;
        int          rel_cycles, hi_cnt, first_hi, mode;
        longint      hb_last;
        logic [63:0] rnd;

        resetn = 1'b0; magic_word = '0; done_override = 1'b0;
        cfg_active = 1'b0; cfg_rx = 1'b0; fab_alive = 1'b0;
        model_reset();
        #2;
        check_all();
        repeat (2) tick();
        resetn = 1'b1;

        // Full qualification and staged release with a steady signature
        magic_word = MAGIC;
        seen_qual = 1'b0; seen_rel = 1'b0; rel_cycles = 0;
        for (int i = 0; i < 400 && m_st != 3; i++) begin
            tick();
            if (seq_state == 2'd1) seen_qual = 1'b1;
            if (seq_state == 2'd2) begin
                seen_rel = 1'b1;
                rel_cycles++;
            end
            if (m_st == 2 && elapsed == STEP) check("first_step", 64'(pad_release[7:4]), 64'h8);
        end
        check("saw_qual", 64'(seen_qual), 64'd1);
        check("saw_release", 64'(seen_rel), 64'd1);
        check("release_len", 64'(rel_cycles), 64'(10 * STEP));
        check("done_pads", 64'(pad_release), 64'h01FFFFFFF80);
        check("done_flag", 64'(fabric_done), 64'd1);

        // Signature loss without config activity is ignored, then revoked
        cfg_active = 1'b0; magic_word = ~MAGIC;
        repeat (20) tick();
        check("done_hold", 64'(seq_state), 64'd3);
        cfg_active = 1'b1;
        tick();
        check("revoke_pads", 64'(pad_release), 64'd0);
        check("revoke_done", 64'(fabric_done), 64'd0);
        cfg_active = 1'b0;
        tick();

        // Short match then drop
        magic_word = MAGIC;
        repeat (5) tick();
        magic_word = ~MAGIC;
        repeat (10) tick();
        check("short_idle", 64'(seq_state), 64'd0);
        check("short_pads", 64'(pad_release), 64'd0);

        // Override pulse from IDLE, then DONE holds with matching signature
        done_override = 1'b1;
        tick();
        check("ovr_pads", 64'(pad_release), 64'h01FFFFFFF80);
        check("ovr_done", 64'(fabric_done), 64'd1);
        done_override = 1'b0; magic_word = MAGIC;
        repeat (10) tick();
        check("ovr_hold", 64'(seq_state), 64'd3);
        cfg_active = 1'b1; magic_word = ~MAGIC;
        repeat (3) tick();
        cfg_active = 1'b0;

        // Override mid-release
        magic_word = MAGIC;
        for (int i = 0; i < 100 && !(m_st == 2 && elapsed >= 40); i++) tick();
        done_override = 1'b1;
        tick();
        check("ovr_rel", 64'(seq_state), 64'd3);
        done_override = 1'b0; cfg_active = 1'b1; magic_word = ~MAGIC;
        repeat (3) tick();
        cfg_active = 1'b0;

        // Signature loss mid-release
        magic_word = MAGIC;
        for (int i = 0; i < 100 && !(m_st == 2 && elapsed >= 50); i++) tick();
        magic_word = ~MAGIC;
        repeat (3) tick();
        check("rel_drop_state", 64'(seq_state), 64'd0);
        check("rel_drop_pads", 64'(pad_release), 64'd0);

        // Receive LED stretch and heartbeat period
        cfg_rx = 1'b1;
        tick();
        cfg_rx = 1'b0;
        hi_cnt = 0; first_hi = -1; hb_have = 1'b0; hb_last = 0; hb_prev = heart_led;
        for (int i = 1; i <= int'(SMAX) + 10; i++) begin
            tick();
            if (rx_led) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (heart_led != hb_prev) begin
                if (hb_have) check("hb_period", 64'(k - hb_last), 64'd512);
                hb_have = 1'b1; hb_last = k; hb_prev = heart_led;
            end
        end
        check("rx_delay", 64'(first_hi), 64'd2);
        check("rx_len", 64'(hi_cnt), 64'(SMAX));

        // Randomized traffic in clean and noisy phases
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) mode = int'($urandom_range(0, 1));
            rnd = {$urandom, $urandom};
            if ((mode == 0 && $urandom_range(0, 399) == 0) || (mode == 1 && $urandom_range(0, 3) == 0))
                magic_word = rnd[47:0];
            else
                magic_word = MAGIC;
            done_override = ($urandom_range(0, 299) == 0);
            cfg_active    = ($urandom_range(0, 7) == 0);
            cfg_rx        = ($urandom_range(0, 49) == 0);
            fab_alive     = 1'($urandom_range(0, 1));
            tick();
        end
        done_override = 1'b0; cfg_active = 1'b1; magic_word = ~MAGIC; cfg_rx = 1'b0;
        repeat (3) tick();
        cfg_active = 1'b0;

        // Asynchronous reset in the middle of a release
        magic_word = MAGIC;
        for (int i = 0; i < 100 && !(m_st == 2 && elapsed >= 20); i++) tick();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_pads", 64'(pad_release), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (30) tick();
        check("post_arst", 64'(seq_state), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
